// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller.
// Stage indices and stop-bit encodings used across the core.
package pipe_stall_ctrl_pkg;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam int CNT_W_DEF = 6;
endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and async active-low clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Per-stage stop/flush decision with a multi-cycle hold countdown.
// Decisions are combinational; only the countdown and statistic are state.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STAGES     = 6,
  parameter int HOLD_STAGE = STG_EX,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int ADDR_W     = 32,
  parameter int STAT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAGES-1:0] stall_req,
  input  logic              hold_start,
  input  logic [CNT_W-1:0]  hold_len,
  input  logic              flush_req,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [STAGES-1:0] stop,
  output logic [STAGES-1:0] flush,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              hold_busy,
  output logic [STAT_W-1:0] stall_cycles
);
  logic [CNT_W-1:0] hold_cnt;
  logic             start_ok;
  logic             hold_act;
  logic             lvl_ok;
  int               lvl;

  assign start_ok = hold_start && (hold_len != '0)
                    && !hold_busy;
  assign hold_act = start_ok || hold_busy;

  always_comb begin
    lvl_ok = 1'b0;
    lvl    = 0;
    for (int i = 1; i < STAGES; i++) begin
      if (stall_req[i]) begin
        lvl_ok = 1'b1;
        lvl    = i;
      end
    end
    if (hold_act && (!lvl_ok || HOLD_STAGE > lvl)) begin
      lvl_ok = 1'b1;
      lvl    = HOLD_STAGE;
    end
  end

  always_comb begin
    stop = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (!flush_req && lvl_ok && k <= lvl)
        stop[k] = STOP;
      else
        stop[k] = NO_STOP;
    end
  end

  always_comb begin
    flush       = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if (flush_req) begin
      flush       = {{(STAGES-1){1'b1}}, 1'b0};
      redirect    = 1'b1;
      redirect_pc = flush_pc;
    end
  end

  // Counter holds the number of cycles left after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      hold_busy <= 1'b0;
    end else if (flush_req) begin
      hold_cnt  <= '0;
      hold_busy <= 1'b0;
    end else if (start_ok) begin
      hold_cnt  <= hold_len - CNT_W'(1);
      hold_busy <= (hold_len > CNT_W'(1));
    end else if (hold_busy) begin
      hold_cnt  <= hold_cnt - CNT_W'(1);
      hold_busy <= (hold_cnt > CNT_W'(1));
    end
  end

  sat_counter #(
    .WIDTH(STAT_W)
  ) u_stat (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (|stop),
    .count(stall_cycles)
  );
endmodule
